rv_iter_divider: RTL and testbench

- Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, built on the same shift primitives as the combinational shift unit.
- Sits beside the ALU in the execute stage and retires one quotient bit per cycle.
- Uses a start/busy/done handshake so the control unit stalls the pipeline while busy is high.

---
 rtl/rv_iter_divider_pkg.sv | 32 +++
 rtl/rv_iter_divider_div_step.sv | 36 +++
 rtl/rv_iter_divider.sv | 149 ++++++++++++++
 tb/tb_rv_iter_divider.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv_iter_divider_pkg.sv
// Shared definitions for the RV32M iterative divider.
// Holds the funct3[1:0] operation encodings, the divider FSM state type,
// the nominal datapath width and the normal-case latency in clock edges.
package rv_iter_divider_pkg;

  localparam int unsigned XLEN = 32;

  // funct3[1:0] of the RV32M divide group
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Edge that samples start counts as edge 1; done is high after this edge.
  localparam int unsigned DIV_LATENCY = XLEN + 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } div_state_e;

  // DIV and REM are signed; DIVU and REMU have op[0] set.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/rv_iter_divider_div_step.sv
// One combinational restoring-division step.
// Shifts {rem, quo} left by one, trial-subtracts the divisor from the new
// remainder at WIDTH+1 bits and keeps the difference when it is non-negative.
// Ports:
//   rem      - current partial remainder
//   quo      - current quotient / remaining dividend bits
//   divisor  - unsigned divisor magnitude
//   rem_next - partial remainder after this step
//   quo_next - quotient after this step (new bit in quo_next[0])
module rv_iter_divider_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    // trial[WIDTH] is the sign bit of the WIDTH+1-bit difference
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv_iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Retires one quotient bit per cycle; the pipeline stalls while busy is high.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   start  - request a division, sampled only while idle
//   a, b   - dividend (rs1) and divisor (rs2)
//   op     - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   busy   - high while a division is in flight
//   done   - one-cycle pulse when result becomes valid
//   result - quotient or remainder, held until the next completion
module rv_iter_divider
  import rv_iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned       CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [WIDTH-1:0] OneW    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, abs_b_q, result_q;
  logic             is_rem_q, q_neg_q, r_neg_q, special_q, done_q;

  logic             is_signed, is_rem, a_neg, b_neg, div_zero, ovf, special;
  logic [WIDTH-1:0] abs_a, abs_b, special_val;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fix_val;

  // Operand decode for the IDLE->start transition
  always_comb begin
    is_signed   = op_is_signed(op);
    is_rem      = op_is_rem(op);
    a_neg       = is_signed & a[WIDTH-1];
    b_neg       = is_signed & b[WIDTH-1];
    // |MinNeg| wraps to MinNeg, which the unsigned datapath reads correctly
    abs_a       = a_neg ? (~a + OneW) : a;
    abs_b       = b_neg ? (~b + OneW) : b;
    div_zero    = (b == '0);
    ovf         = is_signed & (a == MinNeg) & (b == AllOnes);
    special     = div_zero | ovf;
    special_val = div_zero ? (is_rem ? a : AllOnes) : (is_rem ? '0 : MinNeg);
  end

  rv_iter_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (abs_b_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign fix-up; special cases carry their final value in quo_q
  always_comb begin
    if (special_q) begin
      fix_val = quo_q;
    end else if (is_rem_q) begin
      fix_val = r_neg_q ? (~rem_q + OneW) : rem_q;
    end else begin
      fix_val = q_neg_q ? (~quo_q + OneW) : quo_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = special ? StFix : StCalc;
      StCalc:  if (cnt_q == LastCnt) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q != StIdle);
    done   = done_q;
    result = result_q;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      abs_b_q   <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == StFix);
      case (state_q)
        StIdle: begin
          if (start) begin
            is_rem_q  <= is_rem;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            abs_b_q   <= abs_b;
            special_q <= special;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= special ? special_val : abs_a;
          end
        end
        StCalc: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + CntOne;
        end
        StFix: begin
          result_q <= fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_iter_divider.sv
// Self-checking bench for rv_iter_divider: directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_rv_iter_divider;
  import rv_iter_divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [1:0]  op;
  logic        busy, done;
  logic [31:0] result;

  int          n_asserts = 0;
  int          n_fail = 0;
  int          edges;
  logic [31:0] prev_res;

  always #5 clk = ~clk;

  rv_iter_divider #(
    .WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // RISC-V M-extension semantics, written with plain arithmetic
  function automatic logic [31:0] ref_result(input logic [31:0] x, input logic [31:0] y,
                                             input logic [1:0] o);
    int signed sx;
    int signed sy;
    sx = $signed(x);
    sy = $signed(y);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'(sx / sy);
      2'b01:   return x / y;
      2'b10:   return 32'(sx % sy);
      default: return x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [31:0] x, input logic [31:0] y,
                                     input logic [1:0] o);
    if (y == 32'd0) return 2;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return DIV_LATENCY;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Present a request and take edge 1
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top);
    a        = ta;
    b        = tb;
    op       = top;
    start    = 1'b1;
    prev_res = result;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  // Wait (bounded) for done; check latency, value and that result held meanwhile
  task automatic complete(input string tag, input logic [31:0] exp, input int lat);
    bit stable;
    stable = 1'b1;
    while (done !== 1'b1 && edges < 200) begin
      if (result !== prev_res) stable = 1'b0;
      step();
    end
    check({tag, "_latency"}, 32'(edges), 32'(lat));
    check({tag, "_result"}, result, exp);
    check({tag, "_stable"}, {31'b0, stable}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                     input logic [1:0] top, input logic [31:0] exp, input int lat);
    issue(ta, tb, top);
    complete(tag, exp, lat);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    #12;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned and signed cases
    run("divu_100_7", 32'd100, 32'd7, OP_DIVU, 32'd14, 34);
    run("remu_100_7", 32'd100, 32'd7, OP_REMU, 32'd2, 34);
    run("div_m7_2", 32'hFFFF_FFF9, 32'd2, OP_DIV, 32'hFFFF_FFFD, 34);
    run("rem_m7_2", 32'hFFFF_FFF9, 32'd2, OP_REM, 32'hFFFF_FFFF, 34);
    run("div_7_m2", 32'd7, 32'hFFFF_FFFE, OP_DIV, 32'hFFFF_FFFD, 34);

    // Divide by zero
    run("div_by0", 32'd5, 32'd0, OP_DIV, 32'hFFFF_FFFF, 2);
    run("divu_by0", 32'd5, 32'd0, OP_DIVU, 32'hFFFF_FFFF, 2);
    run("rem_by0", 32'd5, 32'd0, OP_REM, 32'd5, 2);
    run("remu_by0", 32'd5, 32'd0, OP_REMU, 32'd5, 2);

    // Signed overflow and its unsigned counterpart
    run("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, 32'h8000_0000, 2);
    run("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, OP_REM, 32'd0, 2);
    run("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, OP_DIVU, 32'd0, 34);

    // start while busy is ignored
    issue(32'd100, 32'd7, OP_DIVU);
    while (edges < 4) step();
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    complete("ignored_start", 32'd14, 34);

    // Back-to-back start in the done cycle
    issue(32'd9, 32'd3, OP_DIVU);
    check("done_drops", {31'b0, done}, 32'd0);
    complete("back_to_back", 32'd3, 34);

    // Reset in the middle of CALC
    issue(32'd1000, 32'd10, OP_DIVU);
    while (edges < 12) step();
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_idle", {31'b0, busy}, 32'd0);
    run("after_rst", 32'd1000, 32'd10, OP_DIVU, 32'd100, 34);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  ro;
      int          mode;
      ra   = $urandom;
      rb   = $urandom;
      ro   = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      case (mode)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 100));
        4: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run("random", ra, rb, ro, ref_result(ra, rb, ro), ref_latency(ra, rb, ro));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
